// File: rtl/ln_stats_accum.sv
// ---------------------------------------------------------------------------
// ln_stats_accum
//
// Streaming statistics stage for layernorm. Accepts LEN signed elements per
// vector over a valid/ready handshake, accumulates sum and sum of squares,
// and produces the vector mean and variance three cycles after the last
// element is accepted. A one-cycle norm_start pulse accompanies the first
// cycle of valid stats and starts the downstream normalize-pass timer.
//
// Parameters:
//   DW   element width (signed two's complement)
//   LEN  elements per vector (power of 2, at least 2)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   in_valid     input element valid
//   in_ready     block can accept an element (high only while accumulating)
//   in_data      signed input element, DW bits
//   stats_valid  mean/variance valid, held until stats_ready
//   stats_ready  consumer accepts stats
//   mean         signed mean, DW bits
//   variance     unsigned variance, 2*DW bits ("var" is a reserved word)
//   norm_start   one-cycle pulse on the first cycle stats are valid
//
// Optional feature:
//   LN_STATS_ROUND_EN  when defined, the divide step rounds half-up instead
//                      of flooring. Latency and the zero clamp on variance
//                      are unchanged.
// ---------------------------------------------------------------------------
module ln_stats_accum #(
  parameter int DW  = 8,
  parameter int LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              stats_valid,
  input  logic              stats_ready,
  output logic [DW-1:0]     mean,
  output logic [2*DW-1:0]   variance,
  output logic              norm_start
);

  localparam int LW  = $clog2(LEN);
  localparam int SW  = DW + LW;       // signed sum width
  localparam int QW  = 2*DW + LW;     // unsigned sum-of-squares width
  localparam int EW  = 2*DW;          // E[x^2] and variance width
  localparam int DFW = 2*DW + 1;      // signed E[x^2] - m^2 difference

  typedef enum logic [1:0] {
    ACC,
    DIV,
    SUB,
    OUT
  } state_t;

  state_t state;
  state_t state_next;

  logic [LW-1:0]        cnt;
  logic signed [SW-1:0] sum;
  logic [QW-1:0]        sumsq;
  logic signed [DW-1:0] m;
  logic [EW-1:0]        ex2;

  logic                 accept;
  logic                 last_elem;
  logic                 release_out;
  logic signed [EW-1:0] elem_sq;
  logic signed [SW-1:0] sum_adj;
  logic [QW-1:0]        sumsq_adj;
  logic signed [EW-1:0] m_sq;
  logic signed [DFW-1:0] diff;

  assign accept      = in_valid && in_ready;
  assign last_elem   = accept && (cnt == LW'(LEN-1));
  assign release_out = (state == OUT) && stats_ready;

  // Signed square of the element; always non-negative, so it is safe to
  // zero-extend into the unsigned accumulator (-128*-128 = 16384 for DW=8).
  assign elem_sq = $signed(in_data) * $signed(in_data);

`ifdef LN_STATS_ROUND_EN
  // Round-half-up: bias by LEN/2 before the shift. The biased values still
  // fit the accumulator widths because the extreme sums are exact multiples
  // of LEN that sit well inside the representable range.
  assign sum_adj   = sum + SW'(LEN/2);
  assign sumsq_adj = sumsq + QW'(LEN/2);
`else
  assign sum_adj   = sum;
  assign sumsq_adj = sumsq;
`endif

  // m*m is at most 2^(2*DW-2), so the 2*DW-bit signed product never wraps.
  assign m_sq = m * m;

  // One extra bit on both operands keeps the difference's sign explicit so
  // a slightly negative result (possible with rounding) can be clamped.
  assign diff = $signed({1'b0, ex2}) - $signed({1'b0, m_sq});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake output. DIV and SUB are single-cycle
  // pipeline steps; OUT waits for the consumer.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (last_elem) begin
          state_next = DIV;
        end
      end
      DIV: begin
        state_next = SUB;
      end
      SUB: begin
        state_next = OUT;
      end
      OUT: begin
        if (stats_ready) begin
          state_next = ACC;
        end
      end
      default: begin
        state_next = ACC;
      end
    endcase
  end

  // Accumulators and element counter. The counter wraps to zero on the
  // last element by construction (LEN is a power of 2); the explicit clear
  // on release also discards anything left from the previous vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sum   <= '0;
      sumsq <= '0;
    end else if (release_out) begin
      cnt   <= '0;
      sum   <= '0;
      sumsq <= '0;
    end else if (accept) begin
      cnt   <= cnt + 1'b1;
      sum   <= sum + {{LW{in_data[DW-1]}}, in_data};
      sumsq <= sumsq + {{LW{1'b0}}, elem_sq};
    end
  end

  // Divide step: power-of-2 divide by shifting. The arithmetic shift gives
  // floor for negative sums; the mean of DW-bit values always fits DW bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      m   <= '0;
      ex2 <= '0;
    end else if (state == DIV) begin
      m   <= DW'(sum_adj >>> LW);
      ex2 <= EW'(sumsq_adj >> LW);
    end
  end

  // Result registers: loaded once in SUB and held through OUT so the
  // consumer sees stable values under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      mean     <= '0;
      variance <= '0;
    end else if (state == SUB) begin
      mean     <= m;
      variance <= diff[DFW-1] ? '0 : diff[EW-1:0];
    end
  end

  // stats_valid mirrors residence in OUT; norm_start fires only on the
  // SUB->OUT transition so backpressure never re-triggers the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stats_valid <= 1'b0;
      norm_start  <= 1'b0;
    end else begin
      stats_valid <= (state_next == OUT);
      norm_start  <= (state == SUB);
    end
  end

endmodule
